rf_op_sequencer: RTL and testbench
==================================

// Module: rf_op_sequencer
// PURPOSE
//  Micro-sequencer that owns all ports of the 4x4 two-read/one-write register
//  file (RF). Accepts one register-transfer instruction over a valid/ready
//  handshake, reads its operands, computes the result, writes it back and
//  reports completion. Sits between the instruction source and the RF. The RF
//  has no reset: its contents are undefined until each register is written.
// PARAMETERS
//  DATA_W  4  RF word width; must match the RF din/dout width
//  ADDR_W  2  RF address width (2**ADDR_W registers)
// PORTS
//  clk          in   1       rising-edge clock, shared with the RF
//  rst_n        in   1       asynchronous active-low reset
//  instr_valid  in   1       instruction present on instr_* this cycle
//  instr_ready  out  1       sequencer can accept an instruction
//  instr_op     in   2       00 LOADI, 01 MOV, 10 ADD, 11 SUB
//  instr_dst    in   ADDR_W  destination register
//  instr_srca   in   ADDR_W  operand A register
//  instr_srcb   in   ADDR_W  operand B register
//  instr_imm    in   DATA_W  immediate value for LOADI
//  rf_rea       out  1       RF read enable, port A
//  rf_reb       out  1       RF read enable, port B
//  rf_raa       out  ADDR_W  RF read address, port A
//  rf_rab       out  ADDR_W  RF read address, port B
//  rf_douta     in   DATA_W  RF read data, port A (combinational from the RF)
//  rf_doutb     in   DATA_W  RF read data, port B
//  rf_we        out  1       RF write enable
//  rf_wa        out  ADDR_W  RF write address
//  rf_din       out  DATA_W  RF write data
//  busy         out  1       high whenever the FSM is not in IDLE
//  done         out  1       one-cycle pulse marking completion of the write
//  result       out  DATA_W  last value written; held until the next write
//  carry        out  1       ADD carry-out or SUB borrow of the last op; 0 for LOADI/MOV
// BEHAVIOUR
//  - FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle each and unconditional after IDLE.
//  - IDLE: instr_ready=1. At a clock edge where instr_valid and instr_ready are both 1,
//    latch op/dst/srca/srcb/imm and go to READ. instr_* inputs are ignored outside IDLE.
//  - READ: raa=srca, rab=srcb. rea=1 for MOV/ADD/SUB; reb=1 for ADD/SUB; otherwise 0.
//    At the end of the cycle, capture rf_douta/rf_doutb into opa/opb.
//  - EXEC: compute a DATA_W+1 bit value.
//      LOADI = imm; MOV = opa; ADD = opa+opb; SUB = opa-opb.
//    Register result = the low DATA_W bits.
//    Register carry = bit DATA_W for ADD, (opa<opb) for SUB, 0 for LOADI/MOV.
//  - WRITE: we=1, wa=dst, din=result. The RF commits the value at the closing edge.
//  - done=1 for exactly the cycle after WRITE (FSM is back in IDLE, so instr_ready=1 too).
//    An instruction offered in that cycle is accepted: throughput is 1 instr per 4 cycles.
//  - Latency: acceptance at edge e0 -> RF write at edge e3 -> done high in cycle e3..e4.
//  - Outside their active state: rea, reb, we = 0; raa, rab, wa, din = 0.
//    All RF controls are decoded from registered state/fields only (no input-to-output paths).
//  - dst equal to srca or srcb is legal: operands are captured in READ, before the write.
//  - Reset (async, any state): FSM returns to IDLE immediately. Latched fields, opa, opb,
//    result, carry, done and busy all go to 0. rf_we drops at once, so an aborted
//    instruction never writes; RF contents are left untouched.
//  - Wrap: ADD/SUB results are modulo 2**DATA_W; carry records the overflow or borrow.
// TESTING
//  1. Reset; LOADI r0=5, then LOADI r1=3 -> writes (wa=0,din=5) then (wa=1,din=3);
//     done 1 cycle after each we; carry=0.
//  2. ADD r2=r0+r1 -> din=8, carry=0. Then LOADI r0=F; ADD r2=r0+r1 -> din=2, carry=1.
//  3. SUB r3=r1-r0 with r1=3, r0=5 -> din=E, carry=1. MOV r1=r3 -> din=E, carry=0,
//     and rea=1, reb=0 during READ.
//  4. Hold instr_valid=1 with 3 different instructions -> instr_ready low in READ/EXEC/WRITE;
//     one accept every 4 cycles; exactly 3 writes, in order, no duplicates.
//  5. Assert rst_n=0 during EXEC of ADD r2=... -> rf_we never rises, busy=0, done=0,
//     result=0; after release, MOV r0=r2 shows r2 unchanged.
//  6. ADD r0=r0+r0 with r0=6 -> din=C, carry=0; a following MOV r1=r0 reads C.

Source files
------------

// File: rtl/rf_op_sequencer.sv
// Four-state micro-sequencer driving a two-read/one-write register file:
// accept instruction, read operands, execute, write back, pulse done.
module rf_op_sequencer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [1:0]        i_instr_op,
  input  logic [ADDR_W-1:0] i_instr_dst,
  input  logic [ADDR_W-1:0] i_instr_srca,
  input  logic [ADDR_W-1:0] i_instr_srcb,
  input  logic [DATA_W-1:0] i_instr_imm,
  output logic              o_rf_rea,
  output logic              o_rf_reb,
  output logic [ADDR_W-1:0] o_rf_raa,
  output logic [ADDR_W-1:0] o_rf_rab,
  input  logic [DATA_W-1:0] i_rf_douta,
  input  logic [DATA_W-1:0] i_rf_doutb,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_wa,
  output logic [DATA_W-1:0] o_rf_din,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  localparam logic [1:0] OP_LOADI = 2'b00;
  localparam logic [1:0] OP_MOV   = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_srca;
  logic [ADDR_W-1:0]   r_srcb;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   r_result;
  logic                r_carry;
  logic                r_done;
  logic                w_accept;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W:0]     w_exec;
  logic                w_exec_carry;

  assign w_accept = i_instr_valid && (r_state == StIdle);
  assign w_sum    = {1'b0, r_opa} + {1'b0, r_opb};
  // Top bit of the widened difference is the borrow, i.e. opa < opb.
  assign w_diff   = {1'b0, r_opa} - {1'b0, r_opb};

  always_comb begin
    w_exec       = '0;
    w_exec_carry = 1'b0;
    unique case (r_op)
      OP_LOADI: w_exec = {1'b0, r_imm};
      OP_MOV:   w_exec = {1'b0, r_opa};
      OP_ADD: begin
        w_exec       = w_sum;
        w_exec_carry = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_exec       = w_diff;
        w_exec_carry = w_diff[DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_dst    <= '0;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_imm    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StWrite);
      if (w_accept) begin
        r_op   <= i_instr_op;
        r_dst  <= i_instr_dst;
        r_srca <= i_instr_srca;
        r_srcb <= i_instr_srcb;
        r_imm  <= i_instr_imm;
      end
      if (r_state == StRead) begin
        r_opa <= i_rf_douta;
        r_opb <= i_rf_doutb;
      end
      if (r_state == StExec) begin
        r_result <= w_exec[DATA_W-1:0];
        r_carry  <= w_exec_carry;
      end
    end
  end

  // RF controls depend only on registered state so no input reaches an output.
  always_comb begin
    w_state_next  = r_state;
    o_instr_ready = 1'b0;
    o_rf_rea      = 1'b0;
    o_rf_reb      = 1'b0;
    o_rf_raa      = '0;
    o_rf_rab      = '0;
    o_rf_we       = 1'b0;
    o_rf_wa       = '0;
    o_rf_din      = '0;
    unique case (r_state)
      StIdle: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) w_state_next = StRead;
      end
      StRead: begin
        o_rf_raa     = r_srca;
        o_rf_rab     = r_srcb;
        o_rf_rea     = (r_op != OP_LOADI);
        o_rf_reb     = (r_op == OP_ADD) || (r_op == OP_SUB);
        w_state_next = StExec;
      end
      StExec: w_state_next = StWrite;
      StWrite: begin
        o_rf_we      = 1'b1;
        o_rf_wa      = r_dst;
        o_rf_din     = r_result;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy   = (r_state != StIdle);
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_carry  = r_carry;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 4x4 register file.
module tb_rf_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [1:0] instr_dst, instr_srca, instr_srcb;
  logic [3:0] instr_imm;
  logic       rf_rea, rf_reb, rf_we;
  logic [1:0] rf_raa, rf_rab, rf_wa;
  logic [3:0] rf_douta, rf_doutb, rf_din;
  logic       busy, done, carry;
  logic [3:0] result;

  logic [3:0] rf_mem [4];
  logic [5:0] wlog [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_op_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_instr_valid(instr_valid),
    .o_instr_ready(instr_ready),
    .i_instr_op   (instr_op),
    .i_instr_dst  (instr_dst),
    .i_instr_srca (instr_srca),
    .i_instr_srcb (instr_srcb),
    .i_instr_imm  (instr_imm),
    .o_rf_rea     (rf_rea),
    .o_rf_reb     (rf_reb),
    .o_rf_raa     (rf_raa),
    .o_rf_rab     (rf_rab),
    .i_rf_douta   (rf_douta),
    .i_rf_doutb   (rf_doutb),
    .o_rf_we      (rf_we),
    .o_rf_wa      (rf_wa),
    .o_rf_din     (rf_din),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_carry      (carry)
  );

  assign rf_douta = rf_mem[rf_raa];
  assign rf_doutb = rf_mem[rf_rab];

  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_wa] <= rf_din;
      wlog.push_back({rf_wa, rf_din});
    end
  end

  // Issues one instruction at a negedge in IDLE and checks every phase; returns at
  // the negedge of the done cycle so a following call is back-to-back.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [1:0] dst,
                       input logic [1:0] a, input logic [1:0] b, input logic [3:0] imm,
                       input logic [3:0] exp_din, input logic exp_c,
                       input logic exp_rea, input logic exp_reb);
    instr_op = op; instr_dst = dst; instr_srca = a; instr_srcb = b; instr_imm = imm;
    instr_valid = 1'b1;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL %s idle_ready got=%b want=1", nm, instr_ready);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    total++;
    if ({busy, instr_ready, rf_rea, rf_reb, rf_raa, rf_rab, rf_we} !==
        {1'b1, 1'b0, exp_rea, exp_reb, a, b, 1'b0}) begin
      bad++;
      $display("FAIL %s read_phase got busy=%b rdy=%b rea=%b reb=%b raa=%0d rab=%0d we=%b want 1 0 %b %b %0d %0d 0",
               nm, busy, instr_ready, rf_rea, rf_reb, rf_raa, rf_rab, rf_we, exp_rea, exp_reb, a, b);
    end
    @(negedge clk);
    total++;
    if ({rf_we, rf_rea, rf_reb, busy} !== 4'b0001) begin
      bad++; $display("FAIL %s exec_phase got we/rea/reb/busy=%b want=0001",
                      nm, {rf_we, rf_rea, rf_reb, busy});
    end
    @(negedge clk);
    total++;
    if ({rf_we, rf_wa, rf_din, carry, result, done} !== {1'b1, dst, exp_din, exp_c, exp_din, 1'b0}) begin
      bad++;
      $display("FAIL %s write_phase got we=%b wa=%0d din=%h c=%b res=%h done=%b want 1 %0d %h %b %h 0",
               nm, rf_we, rf_wa, rf_din, carry, result, done, dst, exp_din, exp_c, exp_din);
    end
    @(negedge clk);
    total++;
    if ({done, rf_we, instr_ready, busy, result, rf_wa, rf_din} !== {4'b1010, exp_din, 2'd0, 4'd0}) begin
      bad++;
      $display("FAIL %s done_phase got done=%b we=%b rdy=%b busy=%b res=%h wa=%0d din=%h want 1 0 1 0 %h 0 0",
               nm, done, rf_we, instr_ready, busy, result, rf_wa, rf_din, exp_din);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0; instr_op = '0; instr_dst = '0;
    instr_srca = '0; instr_srcb = '0; instr_imm = '0;
    @(negedge clk);
    total++;
    if ({busy, done, result, carry, rf_we, rf_rea, rf_reb, instr_ready} !== {10'd0, 1'b1}) begin
      bad++; $display("FAIL reset got busy=%b done=%b res=%h c=%b we=%b rea=%b reb=%b rdy=%b want 0..0 rdy=1",
                      busy, done, result, carry, rf_we, rf_rea, rf_reb, instr_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, instr_ready} !== 3'b001) begin
      bad++; $display("FAIL post_reset got busy/done/rdy=%b want=001", {busy, done, instr_ready});
    end
  endtask

  task automatic test_loadi();
    do_op("loadi_r0_5", 2'b00, 2'd0, 2'd0, 2'd0, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0);
    do_op("loadi_r1_3", 2'b00, 2'd1, 2'd2, 2'd3, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_add();
    do_op("add_5_3", 2'b10, 2'd2, 2'd0, 2'd1, 4'h0, 4'h8, 1'b0, 1'b1, 1'b1);
    do_op("loadi_r0_f", 2'b00, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
    do_op("add_wrap", 2'b10, 2'd2, 2'd0, 2'd1, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_sub_mov();
    do_op("reload_r0_5", 2'b00, 2'd0, 2'd0, 2'd0, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0);
    do_op("sub_borrow", 2'b11, 2'd3, 2'd1, 2'd0, 4'h0, 4'hE, 1'b1, 1'b1, 1'b1);
    do_op("mov_r1_r3", 2'b01, 2'd1, 2'd3, 2'd2, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3] = '{2'b00, 2'b00, 2'b10};
    logic [1:0] dsts[3] = '{2'd0, 2'd1, 2'd2};
    logic [3:0] imms[3] = '{4'h1, 4'h2, 4'h0};
    logic [5:0] exp [3] = '{{2'd0, 4'h1}, {2'd1, 4'h2}, {2'd2, 4'h3}};
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      instr_op = ops[i]; instr_dst = dsts[i]; instr_srca = 2'd0; instr_srcb = 2'd1;
      instr_imm = imms[i]; instr_valid = 1'b1;
      total++;
      if (instr_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_accept%0d got rdy=%b want=1", i, instr_ready);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        total++;
        if (instr_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_busy%0d_%0d got rdy=%b want=0", i, k, instr_ready);
        end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wlog.size() != 3) begin
      bad++; $display("FAIL b2b_count got=%0d want=3", wlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wlog[i] !== exp[i]) begin
          bad++; $display("FAIL b2b_write%0d got=%h want=%h", i, wlog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    n = wlog.size();
    // r0=1, r1=2, r2=3 here; ADD r2=r0+r0 would make r2=2 if it were not aborted.
    instr_op = 2'b10; instr_dst = 2'd2; instr_srca = 2'd0; instr_srcb = 2'd0;
    instr_imm = '0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result, rf_we, instr_ready} !== {7'd0, 1'b1}) begin
      bad++; $display("FAIL abort_reset got busy=%b done=%b res=%h we=%b rdy=%b want 0 0 0 0 1",
                      busy, done, result, rf_we, instr_ready);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (wlog.size() != n) begin
      bad++; $display("FAIL abort_nowrite got writes=%0d want=%0d", wlog.size(), n);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op("mov_r0_r2", 2'b01, 2'd0, 2'd2, 2'd0, 4'h0, 4'h3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_self_alias();
    do_op("loadi_r0_6", 2'b00, 2'd0, 2'd0, 2'd0, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0);
    do_op("add_r0_r0", 2'b10, 2'd0, 2'd0, 2'd0, 4'h0, 4'hC, 1'b0, 1'b1, 1'b1);
    do_op("mov_r1_r0", 2'b01, 2'd1, 2'd0, 2'd0, 4'h0, 4'hC, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_add();
    test_sub_mov();
    test_back_to_back();
    test_reset_abort();
    test_self_alias();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
